// File: rtl/bmem_arb_pkg.sv
// Shared constants and types for the burst-memory arbiter.
package bmem_arb_pkg;

    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int LINE_W      = BEATS * BEAT_W;
    localparam int OFFSET_BITS = 5;

    typedef logic [LINE_W-1:0] bmem_line_t;

    typedef enum logic {
        IDLE,
        WBURST
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over PORTS requesters; one-hot grant plus its index.
// The priority pointer moves past the granted port only when 'advance' is high.
module rr_arbiter #(
    parameter int PORTS = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PORTS-1:0]                         req,
    input  logic                                     advance,
    output logic [PORTS-1:0]                         grant,
    output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] grant_idx,
    output logic                                     grant_valid
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] idx;
    int            cand;

    // Scan requesters starting at the pointer and pick the first one asserted.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        idx         = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            idx = PW'(cand);
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

    // Highest priority moves to the port after the one that just got a command out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && grant_valid) begin
            ptr_q <= (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one banked burst-memory port between icache (port 0) and dcache (port 1).
// Reads are single-cycle commands whose 4-beat responses may come back out of
// order; each returned line is routed by matching its address against the
// outstanding reads. Writes are 4-beat bursts that hold the port until done.
// Optional build macro: BMEM_ARB_PERF_EN adds saturating performance counters
// and sanity assertions; the port list is identical either way.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0][31:0]        req_addr,
    input  logic [PORTS-1:0]              req_read,
    input  logic [PORTS-1:0]              req_write,
    input  logic [PORTS-1:0][LINE_W-1:0]  req_wdata,
    output logic [LINE_W-1:0]             resp_rdata,
    output logic [PORTS-1:0]              resp_valid,
    output logic [31:0]                   bmem_addr,
    output logic                          bmem_read,
    output logic                          bmem_write,
    output logic [BEAT_W-1:0]             bmem_wdata,
    input  logic                          bmem_ready,
    input  logic [31:0]                   bmem_raddr,
    input  logic [BEAT_W-1:0]             bmem_rdata,
    input  logic                          bmem_rvalid
);

    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int BW    = $clog2(BEATS);
    localparam int TAG_W = 32 - OFFSET_BITS;

    arb_state_t                  state_q, state_d;
    logic [PORTS-1:0]            pending_q;
    logic [PORTS-1:0][TAG_W-1:0] pend_addr_q;
    logic [PW-1:0]               wport_q;
    logic [TAG_W-1:0]            wtag_q;
    bmem_line_t                  wline_q;
    logic [BW-1:0]               wbeat_q;
    logic [BW-1:0]               rbeat_q;
    logic [BEAT_W*(BEATS-1)-1:0] rasm_q;

    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic             grant_valid;
    logic             issue_rd;
    logic             issue_wr;
    logic [PORTS-1:0] wr_done;
    logic [PORTS-1:0] tag_hit;
    logic [PORTS-1:0] rd_match;
    logic             line_done;
    logic             unused_addr_bits;

    // Line-offset bits of both request and return addresses carry no meaning.
    assign unused_addr_bits = ^{bmem_raddr[OFFSET_BITS-1:0], req_addr};

    // A port whose completion pulse is showing this cycle still holds its
    // request level; masking it stops the same transaction being issued twice.
    assign eligible = (req_read | req_write) & ~pending_q & ~resp_valid;

    rr_arbiter #(
        .PORTS (PORTS)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (eligible),
        .advance     (issue_rd | issue_wr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Command issue and write-burst sequencing; outputs are quiet while in reset.
    always_comb begin
        state_d    = state_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        wr_done    = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid && bmem_ready && !rst) begin
                    bmem_addr = {req_addr[grant_idx][31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    if (req_write[grant_idx]) begin
                        bmem_write = 1'b1;
                        bmem_wdata = req_wdata[grant_idx][BEAT_W-1:0];
                        issue_wr   = 1'b1;
                        state_d    = WBURST;
                    end else begin
                        bmem_read = 1'b1;
                        issue_rd  = 1'b1;
                    end
                end
            end
            WBURST: begin
                bmem_write = 1'b1;
                bmem_addr  = {wtag_q, {OFFSET_BITS{1'b0}}};
                bmem_wdata = wline_q[int'(wbeat_q)*BEAT_W +: BEAT_W];
                if (bmem_ready && wbeat_q == BW'(BEATS - 1)) begin
                    wr_done[wport_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Find every outstanding read whose line address matches the returning beat.
    always_comb begin
        line_done = bmem_rvalid && (rbeat_q == BW'(BEATS - 1));
        tag_hit   = '0;
        for (int p = 0; p < PORTS; p++) begin
            tag_hit[p] = pending_q[p] && (pend_addr_q[p] == bmem_raddr[31:OFFSET_BITS]);
        end
        rd_match = tag_hit & {PORTS{line_done}};
    end

    // FSM state, outstanding-read bookkeeping, latched write burst, completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            pend_addr_q <= '0;
            wport_q     <= '0;
            wtag_q      <= '0;
            wline_q     <= '0;
            wbeat_q     <= '0;
            resp_valid  <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= rd_match | wr_done;
            pending_q  <= (pending_q & ~rd_match) | (issue_rd ? grant : '0);
            if (issue_rd) begin
                pend_addr_q[grant_idx] <= req_addr[grant_idx][31:OFFSET_BITS];
            end
            if (issue_wr) begin
                wport_q <= grant_idx;
                wtag_q  <= req_addr[grant_idx][31:OFFSET_BITS];
                wline_q <= req_wdata[grant_idx];
                wbeat_q <= BW'(1);
            end else if (state_q == WBURST && bmem_ready) begin
                wbeat_q <= wbeat_q + 1'b1;
            end
        end
    end

    // Assemble returning beats; the completed line is held until the next one lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbeat_q    <= '0;
            rasm_q     <= '0;
            resp_rdata <= '0;
        end else if (bmem_rvalid) begin
            if (rbeat_q == BW'(BEATS - 1)) begin
                resp_rdata <= {bmem_rdata, rasm_q};
            end else begin
                rasm_q[int'(rbeat_q)*BEAT_W +: BEAT_W] <= bmem_rdata;
            end
            rbeat_q <= rbeat_q + 1'b1;
        end
    end

`ifdef BMEM_ARB_PERF_EN
    logic [PORTS-1:0][31:0] grants_q;
    logic [PORTS-1:0][31:0] wait_cycles_q;
    logic [31:0]            bmem_busy_q;
    logic                   cmd_waiting;

    assign cmd_waiting = (state_q == WBURST) || grant_valid;

    // Saturating counters for grants, losing-arbitration cycles and memory stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants_q      <= '0;
            wait_cycles_q <= '0;
            bmem_busy_q   <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if ((issue_rd || issue_wr) && grant[p] && grants_q[p] != '1) begin
                    grants_q[p] <= grants_q[p] + 1'b1;
                end
                if (eligible[p] && !((issue_rd || issue_wr) && grant[p]) && wait_cycles_q[p] != '1) begin
                    wait_cycles_q[p] <= wait_cycles_q[p] + 1'b1;
                end
            end
            if (cmd_waiting && !bmem_ready && bmem_busy_q != '1) begin
                bmem_busy_q <= bmem_busy_q + 1'b1;
            end
        end
    end

    // Returning beats must belong to an outstanding read; strobes never overlap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bmem_rvalid && tag_hit == '0));
            assert (!(bmem_read && bmem_write));
        end
    end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed self-checking bench for bmem_arbiter: a vector table for read
// arbitration plus hand-written sequences for returns, bursts and reset.
module tb_bmem_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_read;
    logic [1:0]        req_write;
    logic [1:0][255:0] req_wdata;
    logic [255:0]      resp_rdata;
    logic [1:0]        resp_valid;
    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [63:0]       bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [63:0]       bmem_rdata;
    logic              bmem_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  rd;
        logic        ready;
        logic        exp_read;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [5];

    bmem_arbiter #(
        .PORTS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr    (req_addr),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .resp_rdata  (resp_rdata),
        .resp_valid  (resp_valid),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr, input logic ready);
        req_read   = rd;
        req_write  = wr;
        bmem_ready = ready;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst         = 1'b1;
        req_read    = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_rdata", resp_rdata, 0);
        checkOutput("rst_bmem_read", bmem_read, 0);
        checkOutput("rst_bmem_write", bmem_write, 0);
        checkOutput("rst_bmem_addr", bmem_addr, 0);
        rst = 1'b0;
    endtask

    task automatic returnLine(input logic [31:0] a, input logic [255:0] ln);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = ln[k*64 +: 64];
            @(negedge clk);
            checkOutput("resp_valid_during_beats", resp_valid, 0);
            nextCycle();
        end
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
    endtask

    initial begin
        logic [255:0] line_a;
        logic [255:0] line_b;
        logic [255:0] wline;

        vecs[0] = '{rd: 2'b00, ready: 1'b1, exp_read: 1'b0, exp_addr: 32'h0000_0000};
        vecs[1] = '{rd: 2'b11, ready: 1'b0, exp_read: 1'b0, exp_addr: 32'h0000_0000};
        vecs[2] = '{rd: 2'b11, ready: 1'b1, exp_read: 1'b1, exp_addr: 32'h1000_0040};
        vecs[3] = '{rd: 2'b11, ready: 1'b1, exp_read: 1'b1, exp_addr: 32'h2000_00A0};
        vecs[4] = '{rd: 2'b11, ready: 1'b1, exp_read: 1'b0, exp_addr: 32'h0000_0000};

        // Table: arbitration order, ready gating, offset masking, pending blocking.
        resetDut();
        req_addr[0] = 32'h1000_0047;
        req_addr[1] = 32'h2000_00A5;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].rd, 2'b00, vecs[i].ready);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_read", i), bmem_read, vecs[i].exp_read);
            checkOutput($sformatf("vec%0d_write", i), bmem_write, 0);
            checkOutput($sformatf("vec%0d_addr", i), bmem_addr, vecs[i].exp_addr);
            nextCycle();
        end

        // Single icache read with a 4-beat return.
        resetDut();
        line_a = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                  64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        req_addr[0] = 32'h1EC0_0040;
        applyStimulus(2'b01, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("single_issue_read", bmem_read, 1);
        checkOutput("single_issue_addr", bmem_addr, 32'h1EC0_0040);
        nextCycle();
        @(negedge clk);
        checkOutput("single_no_reissue", bmem_read, 0);
        nextCycle();
        returnLine(32'h1EC0_0040, line_a);
        @(negedge clk);
        checkOutput("single_resp_valid", resp_valid, 2'b01);
        checkOutput("single_resp_rdata", resp_rdata, line_a);
        applyStimulus(2'b00, 2'b00, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("single_resp_one_cycle", resp_valid, 2'b00);
        nextCycle();

        // Out-of-order returns route by address.
        resetDut();
        line_a = {4{64'h0000_0100_CAFE_0000}} ^ {64'h3, 64'h2, 64'h1, 64'h0};
        line_b = {4{64'h0000_0200_BEEF_0000}} ^ {64'h7, 64'h6, 64'h5, 64'h4};
        req_addr[0] = 32'h0000_0100;
        req_addr[1] = 32'h0000_0200;
        applyStimulus(2'b01, 2'b00, 1'b1);
        nextCycle();
        applyStimulus(2'b11, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("ooo_issue1_read", bmem_read, 1);
        checkOutput("ooo_issue1_addr", bmem_addr, 32'h0000_0200);
        nextCycle();
        returnLine(32'h0000_0200, line_b);
        @(negedge clk);
        checkOutput("ooo_first_valid", resp_valid, 2'b10);
        checkOutput("ooo_first_data", resp_rdata, line_b);
        applyStimulus(2'b01, 2'b00, 1'b1);
        nextCycle();
        returnLine(32'h0000_0100, line_a);
        @(negedge clk);
        checkOutput("ooo_second_valid", resp_valid, 2'b01);
        checkOutput("ooo_second_data", resp_rdata, line_a);
        applyStimulus(2'b00, 2'b00, 1'b1);
        nextCycle();

        // Write burst with a 3-cycle stall on beat 2; read+write on one port picks write.
        resetDut();
        wline = {64'h5733_3333_3333_3333, 64'h5722_2222_2222_2222,
                 64'h5711_1111_1111_1111, 64'h5700_0000_0000_0000};
        req_addr[1]  = 32'h0000_031C;
        req_wdata[1] = wline;
        req_addr[0]  = 32'h0000_0500;
        applyStimulus(2'b10, 2'b10, 1'b1);
        @(negedge clk);
        checkOutput("wr_b0_write", bmem_write, 1);
        checkOutput("wr_b0_read", bmem_read, 0);
        checkOutput("wr_b0_addr", bmem_addr, 32'h0000_0300);
        checkOutput("wr_b0_data", bmem_wdata, wline[63:0]);
        nextCycle();
        applyStimulus(2'b11, 2'b10, 1'b1);
        @(negedge clk);
        checkOutput("wr_b1_read", bmem_read, 0);
        checkOutput("wr_b1_data", bmem_wdata, wline[127:64]);
        nextCycle();
        for (int s = 0; s < 3; s++) begin
            applyStimulus(2'b11, 2'b10, 1'b0);
            @(negedge clk);
            checkOutput("wr_stall_write", bmem_write, 1);
            checkOutput("wr_stall_read", bmem_read, 0);
            checkOutput("wr_stall_addr", bmem_addr, 32'h0000_0300);
            checkOutput("wr_stall_data", bmem_wdata, wline[191:128]);
            nextCycle();
        end
        applyStimulus(2'b11, 2'b10, 1'b1);
        @(negedge clk);
        checkOutput("wr_b2_data", bmem_wdata, wline[191:128]);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_b3_data", bmem_wdata, wline[255:192]);
        checkOutput("wr_b3_addr", bmem_addr, 32'h0000_0300);
        checkOutput("wr_b3_no_resp", resp_valid, 2'b00);
        nextCycle();
        applyStimulus(2'b01, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("wr_resp_valid", resp_valid, 2'b10);
        checkOutput("wr_after_read", bmem_read, 1);
        checkOutput("wr_after_addr", bmem_addr, 32'h0000_0500);
        nextCycle();
        @(negedge clk);
        checkOutput("wr_resp_one_cycle", resp_valid, 2'b00);
        nextCycle();

        // Fairness: after port 0 was served, a simultaneous request favours port 1.
        resetDut();
        line_a = {4{64'h0000_0800_1234_5678}};
        req_addr[0] = 32'h0000_0800;
        applyStimulus(2'b01, 2'b00, 1'b1);
        nextCycle();
        returnLine(32'h0000_0800, line_a);
        @(negedge clk);
        checkOutput("fair_first_valid", resp_valid, 2'b01);
        applyStimulus(2'b00, 2'b00, 1'b1);
        nextCycle();
        req_addr[0] = 32'h0000_0900;
        req_addr[1] = 32'h0000_0A00;
        applyStimulus(2'b11, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("fair_grant_p1_addr", bmem_addr, 32'h0000_0A00);
        nextCycle();
        @(negedge clk);
        checkOutput("fair_grant_p0_addr", bmem_addr, 32'h0000_0900);
        checkOutput("fair_grant_p0_read", bmem_read, 1);
        nextCycle();

        // Same-line reads complete together; a later duplicate return is ignored.
        resetDut();
        line_a = {64'h4444_0000_0000_0400, 64'h3333_0000_0000_0400,
                  64'h2222_0000_0000_0400, 64'h1111_0000_0000_0400};
        req_addr[0] = 32'h0000_0400;
        req_addr[1] = 32'h0000_0400;
        applyStimulus(2'b11, 2'b00, 1'b1);
        nextCycle();
        nextCycle();
        returnLine(32'h0000_0400, line_a);
        @(negedge clk);
        checkOutput("same_line_valid", resp_valid, 2'b11);
        checkOutput("same_line_data", resp_rdata, line_a);
        applyStimulus(2'b00, 2'b00, 1'b0);
        nextCycle();
        returnLine(32'h0000_0400, ~line_a);
        @(negedge clk);
        checkOutput("orphan_return_ignored", resp_valid, 2'b00);
        nextCycle();

        // Asynchronous reset in the middle of a write burst.
        resetDut();
        req_addr[0]  = 32'h0000_0600;
        req_wdata[0] = {4{64'h6666_0000_0000_0006}};
        applyStimulus(2'b00, 2'b01, 1'b1);
        nextCycle();
        nextCycle();
        applyStimulus(2'b00, 2'b01, 1'b0);
        @(negedge clk);
        checkOutput("rst_mid_write_before", bmem_write, 1);
        rst       = 1'b1;
        req_write = 2'b00;
        #1;
        checkOutput("rst_mid_write_drop", bmem_write, 0);
        checkOutput("rst_mid_addr_drop", bmem_addr, 0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        req_addr[0] = 32'h0000_0700;
        applyStimulus(2'b01, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_read", bmem_read, 1);
        checkOutput("post_rst_write", bmem_write, 0);
        checkOutput("post_rst_addr", bmem_addr, 32'h0000_0700);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
